// File: rtl/pll_sup_pkg.sv
// Shared state encoding for the PLL lock supervisor.
// The encoding is exported on the debug state port, so its values must not change.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        RST_PLL   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } pll_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer with asynchronous active-low reset to 0.
// Used for every single-bit level crossing into a local clock domain.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Drives the PLL RESET pin, qualifies LOCK and retries acquisition before releasing sys_rst_n.
// Define PLL_LOCK_SUPERVISOR_STATS_EN to add the saturating relock_cnt lock-loss counter.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RESET_PULSE_CYC  = 24,
    parameter int LOCK_TIMEOUT_CYC = 24000,
    parameter int STABLE_CYC       = 2400,
    parameter int MAX_RETRIES      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pll_lock,
    input  logic        restart,
    output logic        pll_reset,
    output logic        sys_rst_n,
    output logic        locked,
    output logic        fail,
    output logic [2:0]  state
`ifdef PLL_LOCK_SUPERVISOR_STATS_EN
    ,
    output logic [15:0] relock_cnt
`endif
);

    localparam int PULSE_W   = $clog2(RESET_PULSE_CYC + 1);
    localparam int TIMEOUT_W = $clog2(LOCK_TIMEOUT_CYC + 1);
    localparam int STABLE_W  = $clog2(STABLE_CYC + 1);
    localparam int RETRY_W   = $clog2(MAX_RETRIES + 1);

    localparam logic [PULSE_W-1:0]   PULSE_LAST   = PULSE_W'(RESET_PULSE_CYC - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [STABLE_W-1:0]  STABLE_LAST  = STABLE_W'(STABLE_CYC - 1);
    localparam logic [RETRY_W-1:0]   RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    pll_state_e           state_q;
    pll_state_e           state_d;
    logic                 lock_s;
    logic                 enter;
    logic [PULSE_W-1:0]   pulse_cnt;
    logic [TIMEOUT_W-1:0] timeout_cnt;
    logic [STABLE_W-1:0]  stable_cnt;
    logic [RETRY_W-1:0]   retry_cnt;
    logic [RETRY_W-1:0]   retry_d;
    logic                 pll_reset_d;
    logic                 sys_rst_n_d;
    logic                 locked_d;
    logic                 fail_d;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RST_PLL;
            pll_reset <= 1'b1;
            sys_rst_n <= 1'b0;
            locked    <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pll_reset <= pll_reset_d;
            sys_rst_n <= sys_rst_n_d;
            locked    <= locked_d;
            fail      <= fail_d;
        end
    end

    // A counter "reaches" its limit on the edge after it holds LAST, hence the LAST compares.
    always_comb begin
        state_d = state_q;
        retry_d = retry_cnt;
        if (restart) begin
            state_d = RST_PLL;
            retry_d = '0;
        end else begin
            case (state_q)
                RST_PLL: begin
                    if (pulse_cnt == PULSE_LAST) state_d = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = STABLE;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        retry_d = retry_cnt + RETRY_W'(1);
                        state_d = (retry_d == RETRY_LIMIT) ? FAIL : RST_PLL;
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_d = RST_PLL;
                    end else if (stable_cnt == STABLE_LAST) begin
                        state_d = RUN;
                        retry_d = '0;
                    end
                end
                RUN: begin
                    if (!lock_s) state_d = RST_PLL;
                end
                FAIL: begin
                    state_d = FAIL;
                end
                default: begin
                    state_d = RST_PLL;
                end
            endcase
        end
    end

    // Outputs decode the next state so they are registered on the same edge as the state.
    always_comb begin
        pll_reset_d = 1'b0;
        sys_rst_n_d = 1'b0;
        locked_d    = 1'b0;
        fail_d      = 1'b0;
        case (state_d)
            RST_PLL: pll_reset_d = 1'b1;
            RUN: begin
                sys_rst_n_d = 1'b1;
                locked_d    = 1'b1;
            end
            FAIL:    fail_d = 1'b1;
            default: ;
        endcase
    end

    assign enter = restart || (state_d != state_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_cnt   <= '0;
            timeout_cnt <= '0;
            stable_cnt  <= '0;
            retry_cnt   <= '0;
        end else begin
            retry_cnt <= retry_d;
            if (enter) begin
                pulse_cnt   <= '0;
                timeout_cnt <= '0;
                stable_cnt  <= '0;
            end else begin
                case (state_q)
                    RST_PLL:   pulse_cnt   <= pulse_cnt + PULSE_W'(1);
                    WAIT_LOCK: timeout_cnt <= timeout_cnt + TIMEOUT_W'(1);
                    STABLE:    stable_cnt  <= stable_cnt + STABLE_W'(1);
                    default: ;
                endcase
            end
        end
    end

    assign state = state_q;

`ifdef PLL_LOCK_SUPERVISOR_STATS_EN
    // Only genuine lock loss counts; a restart issued while in RUN is not a relock event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            relock_cnt <= '0;
        end else if (!restart && state_q == RUN && !lock_s && relock_cnt != 16'hFFFF) begin
            relock_cnt <= relock_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor with short timing parameters.
// A deadline-based behavioural model is compared against the DUT every clock.
module tb_pll_lock_supervisor;

    localparam int R = 4;
    localparam int T = 50;
    localparam int S = 10;
    localparam int M = 3;

    typedef struct packed {
        int          mode;
        int unsigned start;
        int          retries;
        int          relocks;
    } model_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pll_lock = 1'b0;
    logic        restart = 1'b0;
    logic        pll_reset;
    logic        sys_rst_n;
    logic        locked;
    logic        fail;
    logic [2:0]  state;
`ifdef PLL_LOCK_SUPERVISOR_STATS_EN
    logic [15:0] relock_cnt;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    int unsigned cyc = 0;
    model_t      m = '{mode: 0, start: 0, retries: 0, relocks: 0};
    logic        m_sync1 = 1'b0;
    logic        m_sync2 = 1'b0;

    always #5 clk = ~clk;

    pll_lock_supervisor #(
        .RESET_PULSE_CYC  (R),
        .LOCK_TIMEOUT_CYC (T),
        .STABLE_CYC       (S),
        .MAX_RETRIES      (M)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pll_lock  (pll_lock),
        .restart   (restart),
        .pll_reset (pll_reset),
        .sys_rst_n (sys_rst_n),
        .locked    (locked),
        .fail      (fail),
        .state     (state)
`ifdef PLL_LOCK_SUPERVISOR_STATS_EN
        ,
        .relock_cnt(relock_cnt)
`endif
    );

    // Each phase remembers the edge it began on; leaving is a deadline on the edge number.
    function automatic model_t modelStep(input model_t cur, input int unsigned edge_no,
                                         input logic lock_now, input logic restart_now);
        model_t nxt = cur;
        if (restart_now) begin
            nxt.mode    = 0;
            nxt.start   = edge_no;
            nxt.retries = 0;
        end else begin
            case (cur.mode)
                0: if (edge_no == cur.start + R) begin
                    nxt.mode  = 1;
                    nxt.start = edge_no;
                end
                1: if (lock_now) begin
                    nxt.mode  = 2;
                    nxt.start = edge_no;
                end else if (edge_no == cur.start + T) begin
                    nxt.retries = cur.retries + 1;
                    nxt.mode    = (nxt.retries == M) ? 4 : 0;
                    nxt.start   = edge_no;
                end
                2: if (!lock_now) begin
                    nxt.mode  = 0;
                    nxt.start = edge_no;
                end else if (edge_no == cur.start + S) begin
                    nxt.mode    = 3;
                    nxt.start   = edge_no;
                    nxt.retries = 0;
                end
                3: if (!lock_now) begin
                    nxt.mode    = 0;
                    nxt.start   = edge_no;
                    nxt.relocks = (cur.relocks < 65535) ? cur.relocks + 1 : cur.relocks;
                end
                default: ;
            endcase
        end
        return nxt;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m       <= '{mode: 0, start: cyc, retries: 0, relocks: 0};
            m_sync1 <= 1'b0;
            m_sync2 <= 1'b0;
        end else begin
            m       <= modelStep(m, cyc + 1, m_sync2, restart);
            cyc     <= cyc + 1;
            m_sync1 <= pll_lock;
            m_sync2 <= m_sync1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic compareModel();
        logic [7:0] act;
        logic [7:0] exp;
        act = {1'b0, pll_reset, sys_rst_n, locked, fail, state};
        exp = {1'b0, (m.mode == 0), (m.mode == 3), (m.mode == 3), (m.mode == 4), 3'(m.mode)};
        checkOutput("model_cycle", {24'd0, act}, {24'd0, exp});
`ifdef PLL_LOCK_SUPERVISOR_STATS_EN
        checkOutput("model_relock_cnt", {16'd0, relock_cnt}, 32'(m.relocks));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        compareModel();
    endtask

    task automatic applyStimulus(input logic lock_v, input logic restart_v);
        pll_lock = lock_v;
        restart  = restart_v;
    endtask

    task automatic waitSys(input logic val, input int bound, output int edges);
        edges = bound + 1;
        for (int i = 1; i <= bound; i++) begin
            tick();
            if (sys_rst_n === val) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic waitFail(input int bound, output int edges);
        edges = bound + 1;
        for (int i = 1; i <= bound; i++) begin
            tick();
            if (fail === 1'b1) begin
                edges = i;
                break;
            end
        end
    endtask

    initial begin : stimulus
        int   k;
        int   hi_cnt;
        int   rises;
        int   first_low;
        int   back_high;
        logic prev_rst;
        logic rst_at_low;
        logic saw_sys;

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset_values", {27'd0, pll_reset, sys_rst_n, locked, fail, 1'b0},
                    {27'd0, 5'b10000});
        checkOutput("reset_state", 32'(state), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Power-up acquisition: 4-cycle reset pulse, lock applied 20 cycles after release.
        hi_cnt = (pll_reset === 1'b1) ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pll_reset === 1'b1) hi_cnt++;
        end
        checkOutput("pulse_after_reset", 32'(hi_cnt), 32'd4);
        applyStimulus(1'b1, 1'b0);
        waitSys(1'b1, 40, k);
        checkOutput("lock_to_sys_rst_n", 32'(k), 32'd13);
        checkOutput("locked_in_run", 32'(locked), 32'd1);
        checkOutput("state_run", 32'(state), 32'd3);

        // One-cycle lock drop in RUN, then re-acquisition.
        first_low  = 0;
        back_high  = 0;
        hi_cnt     = 0;
        rst_at_low = 1'b0;
        applyStimulus(1'b0, 1'b0);
        for (int i = 1; i <= 40 && back_high == 0; i++) begin
            tick();
            if (i == 1) applyStimulus(1'b1, 1'b0);
            if (pll_reset === 1'b1) hi_cnt++;
            if (first_low == 0 && sys_rst_n === 1'b0) begin
                first_low  = i;
                rst_at_low = pll_reset;
            end
            if (first_low != 0 && sys_rst_n === 1'b1) back_high = i;
        end
        checkOutput("drop_to_sys_rst_low", 32'(first_low), 32'd3);
        checkOutput("pll_reset_with_drop", 32'(rst_at_low), 32'd1);
        checkOutput("relock_pulse_len", 32'(hi_cnt), 32'd4);
        checkOutput("reacquire_edges", 32'(back_high), 32'd18);
`ifdef PLL_LOCK_SUPERVISOR_STATS_EN
        checkOutput("relock_cnt_one", {16'd0, relock_cnt}, 32'd1);
`endif

        // Lock never returns: three attempts then FAIL.
        applyStimulus(1'b0, 1'b0);
        hi_cnt   = 0;
        rises    = 0;
        prev_rst = pll_reset;
        k        = 301;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (pll_reset === 1'b1) hi_cnt++;
            if (pll_reset === 1'b1 && prev_rst === 1'b0) rises++;
            prev_rst = pll_reset;
            if (fail === 1'b1) begin
                k = i;
                break;
            end
        end
        checkOutput("drop_to_fail_edges", 32'(k), 32'd165);
        checkOutput("fail_reset_pulses", 32'(rises), 32'd3);
        checkOutput("fail_reset_cycles", 32'(hi_cnt), 32'd12);
        checkOutput("fail_outputs", {29'd0, state}, 32'd4);
        checkOutput("fail_pll_reset_low", {30'd0, pll_reset, sys_rst_n}, 32'd0);

        // Restart leaves FAIL and grants a fresh three-attempt budget.
        applyStimulus(1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0);
        checkOutput("restart_clears_fail", {29'd0, fail, pll_reset, 1'b0}, 32'b010);
        checkOutput("restart_state", 32'(state), 32'd0);
        waitFail(300, k);
        checkOutput("fresh_budget_edges", 32'(k), 32'd162);

        // Lock lost at STABLE count 7 after one timeout: the retry count must survive.
        applyStimulus(1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0);
        saw_sys = 1'b0;
        k       = 301;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 60) applyStimulus(1'b1, 1'b0);
            if (i == 68) applyStimulus(1'b0, 1'b0);
            if (i == 70) checkOutput("stable_at_count7", 32'(state), 32'd2);
            if (i == 71) checkOutput("stable_drop_state", 32'(state), 32'd0);
            if (sys_rst_n === 1'b1) saw_sys = 1'b1;
            if (fail === 1'b1) begin
                k = i;
                break;
            end
        end
        checkOutput("sys_rst_never_rose", 32'(saw_sys), 32'd0);
        checkOutput("retry_kept_edges", 32'(k), 32'd179);

        // Asynchronous reset, first mid-STABLE, then mid-RUN.
        applyStimulus(1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) tick();
        checkOutput("mid_stable_state", {29'd0, state}, 32'd2);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_stable", {27'd0, pll_reset, sys_rst_n, locked, fail, 1'b0},
                    {27'd0, 5'b10000});
        checkOutput("async_rst_stable_state", 32'(state), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        waitSys(1'b1, 40, k);
        checkOutput("rerelease_to_run", 32'(k), 32'd15);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_run", {27'd0, pll_reset, sys_rst_n, locked, fail, 1'b0},
                    {27'd0, 5'b10000});
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
